// File: rtl/sifh_hist_sequencer.sv
// sifh_hist_sequencer: per-frame clear/accumulate/scan/report controller for one SiFH histogram RAM.
// Define SIFH_SAT_EN to make bin counts saturate instead of wrapping.
module sifh_hist_sequencer #(
    parameter int BIN_W        = 6,
    parameter int PIX_W        = 2,
    parameter int NB           = PIX_W + BIN_W,
    parameter int CNT_W        = 8,
    parameter int FRAME_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             hit_valid,
    input  logic [NB-1:0]    hit_addr,
    output logic             hit_ready,
    input  logic             cycle_tick,
    output logic [NB-1:0]    waddr,
    output logic             wEnable,
    output logic [CNT_W-1:0] wdata,
    output logic [NB-1:0]    raddr,
    output logic             rEnable,
    input  logic [CNT_W-1:0] rdata,
    output logic             busy,
    output logic             peak_valid,
    output logic [PIX_W-1:0] peak_pixel,
    output logic [BIN_W-1:0] peak_bin,
    output logic [CNT_W-1:0] peak_count,
    output logic             frame_done
);
    localparam int TW = $clog2(FRAME_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(FRAME_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, SCAN, DONE} state_t;

    state_t           state_q;
    logic [NB-1:0]    addr_q, paddr_q, caddr_q;
    logic [TW-1:0]    tick_q;
    logic             pend_q, fwd_q, swept_q, cmp_q;
    logic [CNT_W-1:0] last_q, max_cnt_q, peak_count_q;
    logic [BIN_W-1:0] max_bin_q, peak_bin_q;
    logic [PIX_W-1:0] peak_pixel_q;
    logic             peak_valid_q;

    logic             accept, scan_rd, gt, first;
    logic [BIN_W-1:0] cbin, max_bin_d;
    logic [CNT_W-1:0] max_cnt_d;

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] x);
`ifdef SIFH_SAT_EN
        return (&x) ? x : x + 1'b1;
`else
        return x + 1'b1;
`endif
    endfunction

    always_comb begin
        accept     = state_q == ACCUM && hit_valid;
        scan_rd    = state_q == SCAN && !swept_q;
        hit_ready  = state_q == ACCUM;
        busy       = state_q != IDLE;
        frame_done = state_q == DONE;
        wEnable    = state_q == CLEAR || pend_q;
        waddr      = state_q == CLEAR ? addr_q : (pend_q ? paddr_q : '0);
        // back-to-back hits to one bin read stale RAM data, so reuse the count still being written
        wdata      = pend_q ? inc(fwd_q ? last_q : rdata) : '0;
        rEnable    = accept || scan_rd;
        raddr      = accept ? hit_addr : (scan_rd ? addr_q : '0);
        cbin       = caddr_q[BIN_W-1:0];
        first      = cbin == '0;
        gt         = rdata > max_cnt_q;
        max_bin_d  = first ? '0 : (gt ? cbin : max_bin_q);
        max_cnt_d  = (first || gt) ? rdata : max_cnt_q;
    end

    assign peak_valid = peak_valid_q;
    assign peak_pixel = peak_pixel_q;
    assign peak_bin   = peak_bin_q;
    assign peak_count = peak_count_q;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            paddr_q      <= '0;
            caddr_q      <= '0;
            tick_q       <= '0;
            pend_q       <= 1'b0;
            fwd_q        <= 1'b0;
            swept_q      <= 1'b0;
            cmp_q        <= 1'b0;
            last_q       <= '0;
            max_cnt_q    <= '0;
            max_bin_q    <= '0;
            peak_valid_q <= 1'b0;
            peak_pixel_q <= '0;
            peak_bin_q   <= '0;
            peak_count_q <= '0;
        end else begin
            peak_valid_q <= 1'b0;
            cmp_q        <= scan_rd;
            caddr_q      <= addr_q;
            if (cmp_q) begin
                max_bin_q <= max_bin_d;
                max_cnt_q <= max_cnt_d;
                if (&cbin) begin
                    peak_valid_q <= 1'b1;
                    peak_pixel_q <= caddr_q[NB-1:BIN_W];
                    peak_bin_q   <= max_bin_d;
                    peak_count_q <= max_cnt_d;
                end
            end
            case (state_q)
                IDLE: begin
                    tick_q  <= '0;
                    addr_q  <= '0;
                    swept_q <= 1'b0;
                    if (start) state_q <= CLEAR;
                end
                CLEAR: begin
                    addr_q <= addr_q + 1'b1;
                    if (&addr_q) state_q <= ACCUM;
                end
                ACCUM: begin
                    pend_q  <= accept;
                    paddr_q <= hit_addr;
                    fwd_q   <= accept && pend_q && hit_addr == paddr_q;
                    if (pend_q) last_q <= wdata;
                    if (cycle_tick) begin
                        tick_q <= tick_q + 1'b1;
                        if (tick_q == TICK_LAST) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    pend_q  <= 1'b0;
                    fwd_q   <= 1'b0;
                    state_q <= SCAN;
                end
                SCAN: begin
                    if (!swept_q) begin
                        addr_q <= addr_q + 1'b1;
                        if (&addr_q) swept_q <= 1'b1;
                    end
                    if (peak_valid_q && &peak_pixel_q) state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
